// File: rtl/multicycle_control.sv
// Multi-cycle control FSM (IF->DEC->EXEC->MEM->WB) with a variable-latency data memory handshake.
// Define ILLEGAL_TRAP_EN to trap undecoded opcodes; otherwise they retire as NOPs.
module multicycle_control #(
    parameter int ALU_FUNC_W = 4,
    parameter int CNT_W      = 32
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [31:0]           Instr,
    input  logic                  Zero,
    input  logic                  Mem_Ack,
    output logic                  IR_LdEn,
    output logic                  PC_Sel,
    output logic                  PC_LdEn,
    output logic                  RF_WrEn,
    output logic                  RF_WrData_sel,
    output logic                  RF_B_sel,
    output logic                  ALU_Bin_sel,
    output logic [ALU_FUNC_W-1:0] ALU_func,
    output logic                  Mem_Req,
    output logic                  Mem_WrEn,
    output logic [CNT_W-1:0]      Instr_Cnt,
    output logic                  Illegal
);

    typedef enum logic [2:0] {
        S_IF, S_DEC, S_EXEC, S_MEM, S_WB, S_TRAP
    } state_t;

    localparam logic [5:0] OP_ALUR = 6'b100000;
    localparam logic [5:0] OP_LI   = 6'b111000;
    localparam logic [5:0] OP_ADDI = 6'b110000;
    localparam logic [5:0] OP_ANDI = 6'b110010;
    localparam logic [5:0] OP_ORI  = 6'b110011;
    localparam logic [5:0] OP_LW   = 6'b001111;
    localparam logic [5:0] OP_LB   = 6'b000011;
    localparam logic [5:0] OP_SW   = 6'b011111;
    localparam logic [5:0] OP_SB   = 6'b000111;
    localparam logic [5:0] OP_B    = 6'b111111;
    localparam logic [5:0] OP_BEQ  = 6'b000000;
    localparam logic [5:0] OP_BNE  = 6'b000001;

    state_t                  state, stateNext;
    logic [5:0]              opcode;
    logic [ALU_FUNC_W-1:0]   func;
    logic                    isAluR, isImm, isLoad, isStore, isB, isBeq, isBne, isLegal;
    logic                    unusedInstr;

    // Only opcode and the low func bits are of interest to control.
    assign unusedInstr = ^Instr[25:ALU_FUNC_W];

    assign isAluR  = (opcode == OP_ALUR);
    assign isImm   = (opcode == OP_LI) || (opcode == OP_ADDI) ||
                     (opcode == OP_ANDI) || (opcode == OP_ORI);
    assign isLoad  = (opcode == OP_LW) || (opcode == OP_LB);
    assign isStore = (opcode == OP_SW) || (opcode == OP_SB);
    assign isB     = (opcode == OP_B);
    assign isBeq   = (opcode == OP_BEQ);
    assign isBne   = (opcode == OP_BNE);
    assign isLegal = isAluR || isImm || isLoad || isStore || isB || isBeq || isBne;

    always_comb begin
        stateNext = state;
        case (state)
            S_IF:   stateNext = S_DEC;
            S_DEC:  stateNext = S_EXEC;
            S_EXEC: begin
                if (isAluR || isImm)
                    stateNext = S_WB;
                else if (isLoad || isStore)
                    stateNext = S_MEM;
                else if (isLegal)
                    stateNext = S_IF;
                else
`ifdef ILLEGAL_TRAP_EN
                    stateNext = S_TRAP;
`else
                    stateNext = S_IF;
`endif
            end
            S_MEM:  if (Mem_Ack) stateNext = isStore ? S_IF : S_WB;
            S_WB:   stateNext = S_IF;
            S_TRAP: stateNext = S_TRAP;
            default: stateNext = S_IF;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state  <= S_IF;
            opcode <= '0;
            func   <= '0;
        end else begin
            state <= stateNext;
            if (state == S_IF) begin
                opcode <= Instr[31:26];
                func   <= Instr[ALU_FUNC_W-1:0];
            end
        end
    end

    // Outputs decode registered state/opcode; Reset gates them low asynchronously.
    always_comb begin
        IR_LdEn       = 1'b0;
        PC_Sel        = 1'b0;
        PC_LdEn       = 1'b0;
        RF_WrEn       = 1'b0;
        RF_WrData_sel = 1'b0;
        RF_B_sel      = 1'b0;
        ALU_Bin_sel   = 1'b0;
        ALU_func      = '0;
        Mem_Req       = 1'b0;
        Mem_WrEn      = 1'b0;
        if (Reset) begin
            // ALU controls stay stable from EXEC until the instruction retires.
            if (state == S_EXEC || state == S_MEM || state == S_WB) begin
                ALU_Bin_sel = isImm || isLoad || isStore;
                if (isAluR)
                    ALU_func = func;
                else if (opcode == OP_ANDI)
                    ALU_func = ALU_FUNC_W'(2);
                else if (opcode == OP_ORI)
                    ALU_func = ALU_FUNC_W'(3);
                else if (isBeq || isBne)
                    ALU_func = ALU_FUNC_W'(1);
            end
            case (state)
                S_IF:   IR_LdEn = 1'b1;
                S_DEC:  RF_B_sel = !(isAluR || isB);
                S_EXEC: begin
                    PC_Sel = isB || (isBeq && Zero) || (isBne && !Zero);
`ifdef ILLEGAL_TRAP_EN
                    PC_LdEn = isB || isBeq || isBne;
`else
                    PC_LdEn = isB || isBeq || isBne || !isLegal;
`endif
                end
                S_MEM: begin
                    Mem_Req  = 1'b1;
                    Mem_WrEn = isStore;
                    PC_LdEn  = Mem_Ack && isStore;
                end
                S_WB: begin
                    RF_WrEn       = 1'b1;
                    PC_LdEn       = 1'b1;
                    RF_WrData_sel = !isLoad;
                end
                default: ;
            endcase
        end
    end

`ifdef ILLEGAL_TRAP_EN
    assign Illegal = Reset && (state == S_TRAP);
`else
    assign Illegal = 1'b0;
`endif

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)
            Instr_Cnt <= '0;
        else if (PC_LdEn)
            Instr_Cnt <= Instr_Cnt + 1'b1;
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-cycle expected control vectors are queued by
// the driver and popped/compared by an independent negedge monitor. Counter is 4 bits to reach wrap.
module tb_multicycle_control;

    localparam int CW = 4;

    localparam logic [9:0] F_IR  = 10'b1000000000;
    localparam logic [9:0] F_PCS = 10'b0100000000;
    localparam logic [9:0] F_PCL = 10'b0010000000;
    localparam logic [9:0] F_RFW = 10'b0001000000;
    localparam logic [9:0] F_WD  = 10'b0000100000;
    localparam logic [9:0] F_RFB = 10'b0000010000;
    localparam logic [9:0] F_BS  = 10'b0000001000;
    localparam logic [9:0] F_MRQ = 10'b0000000100;
    localparam logic [9:0] F_MWR = 10'b0000000010;
    localparam logic [9:0] F_ILL = 10'b0000000001;

    localparam logic [31:0] I_ADDI = 32'hC000_0000;
    localparam logic [31:0] I_ALUR = 32'h8000_0004;
    localparam logic [31:0] I_BEQ  = 32'h0000_0000;
    localparam logic [31:0] I_BNE  = 32'h0400_0000;
    localparam logic [31:0] I_B    = 32'hFC00_0000;
    localparam logic [31:0] I_LW   = 32'h3C00_0000;
    localparam logic [31:0] I_SB   = 32'h1C00_0000;
    localparam logic [31:0] I_SW   = 32'h7C00_0000;
    localparam logic [31:0] I_ORI  = 32'hCC00_0000;
    localparam logic [31:0] I_ILL  = 32'hA800_0000;

    typedef struct {
        string          nm;
        logic [9:0]     f;
        logic [3:0]     fn;
        logic [CW-1:0]  cnt;
    } exp_t;

    logic          Clk, Reset, Zero, Mem_Ack;
    logic [31:0]   Instr;
    logic          IR_LdEn, PC_Sel, PC_LdEn, RF_WrEn, RF_WrData_sel, RF_B_sel, ALU_Bin_sel;
    logic [3:0]    ALU_func;
    logic          Mem_Req, Mem_WrEn, Illegal;
    logic [CW-1:0] Instr_Cnt;

    exp_t expQ[$];
    int   checks = 0;
    int   failures = 0;

    multicycle_control #(.ALU_FUNC_W(4), .CNT_W(CW)) dut (
        .Clk(Clk), .Reset(Reset), .Instr(Instr), .Zero(Zero), .Mem_Ack(Mem_Ack),
        .IR_LdEn(IR_LdEn), .PC_Sel(PC_Sel), .PC_LdEn(PC_LdEn), .RF_WrEn(RF_WrEn),
        .RF_WrData_sel(RF_WrData_sel), .RF_B_sel(RF_B_sel), .ALU_Bin_sel(ALU_Bin_sel),
        .ALU_func(ALU_func), .Mem_Req(Mem_Req), .Mem_WrEn(Mem_WrEn),
        .Instr_Cnt(Instr_Cnt), .Illegal(Illegal)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Monitor: one expected vector per driven cycle, sampled mid-cycle.
    always @(negedge Clk) begin
        if (expQ.size() != 0) begin
            exp_t e;
            logic [9:0] gotF;
            e = expQ.pop_front();
            gotF = {IR_LdEn, PC_Sel, PC_LdEn, RF_WrEn, RF_WrData_sel, RF_B_sel,
                    ALU_Bin_sel, Mem_Req, Mem_WrEn, Illegal};
            checks++;
            if (gotF !== e.f || ALU_func !== e.fn || Instr_Cnt !== e.cnt) begin
                failures++;
                $display("FAIL %s: got flags=%b func=%h cnt=%0d, expected flags=%b func=%h cnt=%0d",
                         e.nm, gotF, ALU_func, Instr_Cnt, e.f, e.fn, e.cnt);
            end
        end
    end

    task automatic step(input logic rst, input logic [31:0] ins, input logic z, input logic ack,
                        input string nm, input logic [9:0] f, input logic [3:0] fn, input int cnt);
        exp_t e;
        @(posedge Clk);
        #1;
        Reset   = rst;
        Instr   = ins;
        Zero    = z;
        Mem_Ack = ack;
        e.nm  = nm;
        e.f   = f;
        e.fn  = fn;
        e.cnt = cnt[CW-1:0];
        expQ.push_back(e);
    endtask

    initial begin
        Reset = 1'b0; Instr = '0; Zero = 1'b0; Mem_Ack = 1'b0;
        step(0, I_ADDI, 1, 1, "reset_idle", '0, 4'h0, 0);
        step(0, I_ADDI, 1, 1, "reset_idle2", '0, 4'h0, 0);

        // addi then ALU-R func=4
        step(1, I_ADDI, 0, 0, "addi_if",   F_IR, 4'h0, 0);
        step(1, I_ADDI, 0, 0, "addi_dec",  F_RFB, 4'h0, 0);
        step(1, I_ADDI, 0, 0, "addi_exec", F_BS, 4'h0, 0);
        step(1, I_ADDI, 0, 0, "addi_wb",   F_RFW | F_WD | F_PCL | F_BS, 4'h0, 0);
        step(1, I_ALUR, 0, 0, "alur_if",   F_IR, 4'h0, 1);
        step(1, I_ALUR, 0, 0, "alur_dec",  '0, 4'h0, 1);
        step(1, I_ALUR, 0, 0, "alur_exec", '0, 4'h4, 1);
        step(1, I_ALUR, 0, 0, "alur_wb",   F_RFW | F_WD | F_PCL, 4'h4, 1);

        // conditional branches with Zero=1
        step(1, I_BEQ, 1, 0, "beq_if",   F_IR, 4'h0, 2);
        step(1, I_BEQ, 1, 0, "beq_dec",  F_RFB, 4'h0, 2);
        step(1, I_BEQ, 1, 0, "beq_exec", F_PCS | F_PCL, 4'h1, 2);
        step(1, I_BNE, 1, 0, "bne_if",   F_IR, 4'h0, 3);
        step(1, I_BNE, 1, 0, "bne_dec",  F_RFB, 4'h0, 3);
        step(1, I_BNE, 1, 0, "bne_exec", F_PCL, 4'h1, 3);
        step(1, I_B,   0, 0, "b_if",     F_IR, 4'h0, 4);
        step(1, I_B,   0, 0, "b_dec",    '0, 4'h0, 4);
        step(1, I_B,   0, 0, "b_exec",   F_PCS | F_PCL, 4'h0, 4);

        // lw with three wait cycles
        step(1, I_LW, 0, 0, "lw_if",   F_IR, 4'h0, 5);
        step(1, I_LW, 0, 0, "lw_dec",  F_RFB, 4'h0, 5);
        step(1, I_LW, 0, 0, "lw_exec", F_BS, 4'h0, 5);
        for (int i = 0; i < 3; i++)
            step(1, I_LW, 0, 0, "lw_mem_wait", F_MRQ | F_BS, 4'h0, 5);
        step(1, I_LW, 0, 1, "lw_mem_ack", F_MRQ | F_BS, 4'h0, 5);
        step(1, I_LW, 0, 0, "lw_wb",      F_RFW | F_PCL | F_BS, 4'h0, 5);

        // sb with zero-wait ack
        step(1, I_SB, 0, 0, "sb_if",   F_IR, 4'h0, 6);
        step(1, I_SB, 0, 0, "sb_dec",  F_RFB, 4'h0, 6);
        step(1, I_SB, 0, 0, "sb_exec", F_BS, 4'h0, 6);
        step(1, I_SB, 0, 1, "sb_mem",  F_MRQ | F_MWR | F_PCL | F_BS, 4'h0, 6);

        // ori with Mem_Ack held high outside MEM
        step(1, I_ORI, 0, 1, "ori_if",   F_IR, 4'h0, 7);
        step(1, I_ORI, 0, 1, "ori_dec",  F_RFB, 4'h0, 7);
        step(1, I_ORI, 0, 1, "ori_exec", F_BS, 4'h3, 7);
        step(1, I_ORI, 0, 1, "ori_wb",   F_RFW | F_WD | F_PCL | F_BS, 4'h3, 7);

        // nine b instructions take the 4-bit counter 8 -> 15 -> 0 -> 1
        for (int i = 0; i < 9; i++) begin
            step(1, I_B, 0, 0, "wrap_b_if",   F_IR, 4'h0, (8 + i) % 16);
            step(1, I_B, 0, 0, "wrap_b_dec",  '0, 4'h0, (8 + i) % 16);
            step(1, I_B, 0, 0, "wrap_b_exec", F_PCS | F_PCL, 4'h0, (8 + i) % 16);
        end

        // sw aborted by reset while in MEM
        step(1, I_SW, 0, 0, "sw_if",    F_IR, 4'h0, 1);
        step(1, I_SW, 0, 0, "sw_dec",   F_RFB, 4'h0, 1);
        step(1, I_SW, 0, 0, "sw_exec",  F_BS, 4'h0, 1);
        step(1, I_SW, 0, 0, "sw_mem",   F_MRQ | F_MWR | F_BS, 4'h0, 1);
        step(0, I_SW, 0, 0, "sw_abort", '0, 4'h0, 0);

        // undecoded opcode 101010
        step(1, I_ILL, 0, 0, "ill_if",  F_IR, 4'h0, 0);
        step(1, I_ILL, 0, 0, "ill_dec", F_RFB, 4'h0, 0);
`ifdef ILLEGAL_TRAP_EN
        step(1, I_ILL, 0, 0, "ill_exec", '0, 4'h0, 0);
        for (int i = 0; i < 10; i++)
            step(1, I_ADDI, 1, 1, "trap_hold", F_ILL, 4'h0, 0);
`else
        step(1, I_ILL, 0, 0, "nop_exec", F_PCL, 4'h0, 0);
        step(1, I_ADDI, 0, 0, "nop_retired_if", F_IR, 4'h0, 1);
`endif

        for (int i = 0; i < 20 && expQ.size() != 0; i++)
            @(posedge Clk);
        if (expQ.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expected vectors never compared, required 0", expQ.size());
        end
        @(posedge Clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
